reg_writeback_buffer: RTL

REG_WRITEBACK_BUFFER -- requirements
Module: reg_writeback_buffer

---
 rtl/reg_writeback_buffer_if.sv | 40 ++++
 rtl/reg_writeback_buffer.sv | 95 +++++++++
 2 files changed

// File: rtl/reg_writeback_buffer_if.sv
// Writeback handshake, register-file write port and bypass lookup
// bundle for reg_writeback_buffer.
interface reg_writeback_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          InValid;
  logic          InReady;
  logic [4:0]    InRW;
  logic [31:0]   InData;
  logic          DrainEn;
  logic [4:0]    RW;
  logic [31:0]   BusW;
  logic          RegWr;
  logic [4:0]    RA;
  logic [4:0]    RB;
  logic          HitA;
  logic          HitB;
  logic [31:0]   FwdA;
  logic [31:0]   FwdB;
  logic [CW-1:0] Count;
  logic          Empty;

  modport master (
    output InValid, InRW, InData,
    output DrainEn, RA, RB,
    input  InReady, RW, BusW, RegWr,
    input  HitA, HitB, FwdA, FwdB,
    input  Count, Empty
  );

  modport slave (
    input  InValid, InRW, InData,
    input  DrainEn, RA, RB,
    output InReady, RW, BusW, RegWr,
    output HitA, HitB, FwdA, FwdB,
    output Count, Empty
  );
endinterface

// File: rtl/reg_writeback_buffer.sv
// Circular writeback FIFO in front of the register-file write port,
// with youngest-match bypass lookup for two read ports.
module reg_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input logic Clk,
  input logic Reset_n,
  reg_writeback_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    mem_rw   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          hit_a;
  logic          hit_b;
  logic [31:0]   fwd_a;
  logic [31:0]   fwd_b;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // r0 writes complete the handshake but are never stored
  assign push = bus.InValid && !full
             && (bus.InRW != 5'd0);
  assign pop  = bus.DrainEn && !empty;

  assign bus.InReady = !full;
  assign bus.RegWr   = pop;
  assign bus.RW      = empty ? '0
                     : mem_rw[rd_ptr];
  assign bus.BusW    = empty ? '0
                     : mem_data[rd_ptr];
  assign bus.Count   = count;
  assign bus.Empty   = empty;
  assign bus.HitA    = hit_a;
  assign bus.HitB    = hit_b;
  assign bus.FwdA    = fwd_a;
  assign bus.FwdB    = fwd_b;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_rw[wr_ptr]   <= bus.InRW;
      mem_data[wr_ptr] <= bus.InData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins
  always_comb begin
    logic [AW-1:0] idx;
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (CW'(k) < count) begin
        if (bus.RA != 5'd0
            && mem_rw[idx] == bus.RA) begin
          hit_a = 1'b1;
          fwd_a = mem_data[idx];
        end
        if (bus.RB != 5'd0
            && mem_rw[idx] == bus.RB) begin
          hit_b = 1'b1;
          fwd_b = mem_data[idx];
        end
      end
    end
  end
endmodule
